// File: rtl/sound_dsm_dac_pkg.sv
// ---------------------------------------------------------------------------
// sound_dsm_dac_pkg
// Shared definitions for the sound output DAC path.
//   SAMPLE_WIDTH      : width of the mixed PCM sample carried by the sound
//                       interface; must match SOUND_IF.Signal.
//   to_offset_binary  : two's-complement sample -> offset-binary code
//                       (most negative -> 0, zero -> mid-scale).
// ---------------------------------------------------------------------------
package sound_dsm_dac_pkg;

    localparam int SAMPLE_WIDTH = 16;

    // Adding 2^(W-1) modulo 2^W is the same as inverting the MSB.
    function automatic logic [SAMPLE_WIDTH-1:0] to_offset_binary(
        input logic signed [SAMPLE_WIDTH-1:0] s
    );
        return {~s[SAMPLE_WIDTH-1], s[SAMPLE_WIDTH-2:0]};
    endfunction

endpackage

// File: rtl/dsm_modulator_1st.sv
// ---------------------------------------------------------------------------
// dsm_modulator_1st
// First-order delta-sigma modulator. Every MOD_DIV clocks the unsigned level
// U is added into a WIDTH-bit accumulator; the carry out is the output bit,
// so the long-run density of ones on DOUT is U / 2^WIDTH.
// Ports:
//   CLK      in   system clock
//   RESET_n  in   asynchronous active-low reset
//   U        in   WIDTH  offset-binary level to modulate
//   DOUT     out  1      registered bitstream
// ---------------------------------------------------------------------------
module dsm_modulator_1st
    import sound_dsm_dac_pkg::*;
#(
    parameter int WIDTH   = SAMPLE_WIDTH,
    parameter int MOD_DIV = 1
) (
    input  logic             CLK,
    input  logic             RESET_n,
    input  logic [WIDTH-1:0] U,
    output logic             DOUT
);

    // Divider width; at least one bit so MOD_DIV=1 still elaborates.
    localparam int MDW = (MOD_DIV > 1) ? $clog2(MOD_DIV) : 1;

    logic [MDW-1:0] mod_cnt;
    logic           mod_step;
    logic [WIDTH-1:0] acc;
    logic [WIDTH:0]   sum;

    assign mod_step = (mod_cnt == MDW'(MOD_DIV - 1));
    assign sum      = {1'b0, acc} + {1'b0, U};

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            mod_cnt <= '0;
            acc     <= '0;
            DOUT    <= 1'b0;
        end else begin
            if (mod_step) begin
                mod_cnt <= '0;
                acc     <= sum[WIDTH-1:0];
                DOUT    <= sum[WIDTH];
            end else begin
                mod_cnt <= mod_cnt + MDW'(1);
            end
        end
    end

endmodule

// File: rtl/sound_dsm_dac.sv
// ---------------------------------------------------------------------------
// sound_dsm_dac
// Converts the mixed signed PCM sample to a 1-bit delta-sigma stream for an
// external RC filter, with a soft-start / soft-mute gain ramp so reset, boot
// and mute transitions do not pop.
// Ports:
//   CLK         in   system clock
//   RESET_n     in   asynchronous active-low reset
//   SIGNAL      in   IN_WIDTH      signed PCM sample (two's complement)
//   MUTE        in   1             1 = ramp gain to 0, 0 = ramp to full scale
//   DOUT        out  1             registered delta-sigma bitstream
//   GAIN        out  GAIN_BITS+1   current gain (2^GAIN_BITS = unity)
//   SAMPLE_STB  out  1             high for the cycle a sample is captured
// ---------------------------------------------------------------------------
module sound_dsm_dac
    import sound_dsm_dac_pkg::*;
#(
    parameter int IN_WIDTH   = SAMPLE_WIDTH,
    parameter int SAMPLE_DIV = 256,
    parameter int GAIN_BITS  = 8,
    parameter int MOD_DIV    = 1
) (
    input  logic                 CLK,
    input  logic                 RESET_n,
    input  logic [IN_WIDTH-1:0]  SIGNAL,
    input  logic                 MUTE,
    output logic                 DOUT,
    output logic [GAIN_BITS:0]   GAIN,
    output logic                 SAMPLE_STB
);

    localparam int SW = $clog2(SAMPLE_DIV);
    localparam int GW = GAIN_BITS + 1;
    // Two guard bits: one for the sign of the gain operand, one headroom.
    localparam int PW = IN_WIDTH + GAIN_BITS + 2;
    localparam logic [GW-1:0] GAIN_FULL = {1'b1, {GAIN_BITS{1'b0}}};

    logic [SW-1:0]              samp_cnt;
    logic signed [IN_WIDTH-1:0] sample_r;
    logic [GW-1:0]              gain_r;
    logic [GW-1:0]              gain_tgt;
    logic signed [PW-1:0]       samp_ext;
    logic signed [PW-1:0]       gain_ext;
    logic signed [PW-1:0]       prod;
    logic signed [IN_WIDTH-1:0] scaled_r;
    logic [IN_WIDTH-1:0]        u_off;

    assign SAMPLE_STB = (samp_cnt == SW'(SAMPLE_DIV - 1));
    assign GAIN       = gain_r;
    assign gain_tgt   = MUTE ? '0 : GAIN_FULL;

    // Sample divider, capture register and gain ramp. The ramp moves one
    // step per captured sample toward the target, so it cannot overshoot.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            samp_cnt <= '0;
            sample_r <= '0;
            gain_r   <= '0;
        end else if (SAMPLE_STB) begin
            samp_cnt <= '0;
            sample_r <= SIGNAL;
            if (gain_r < gain_tgt) begin
                gain_r <= gain_r + GW'(1);
            end else if (gain_r > gain_tgt) begin
                gain_r <= gain_r - GW'(1);
            end
        end else begin
            samp_cnt <= samp_cnt + SW'(1);
        end
    end

    // Gain is non-negative, so it is zero-extended into the signed operand.
    assign samp_ext = {{(PW-IN_WIDTH){sample_r[IN_WIDTH-1]}}, sample_r};
    assign gain_ext = {{(PW-GW){1'b0}}, gain_r};
    assign prod     = samp_ext * gain_ext;

    // |gain| <= 2^GAIN_BITS, so the shifted product always fits IN_WIDTH.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            scaled_r <= '0;
        end else begin
            scaled_r <= IN_WIDTH'(prod >>> GAIN_BITS);
        end
    end

    generate
        if (IN_WIDTH == SAMPLE_WIDTH) begin : g_pkg_offset
            assign u_off = to_offset_binary(scaled_r);
        end else begin : g_local_offset
            assign u_off = {~scaled_r[IN_WIDTH-1], scaled_r[IN_WIDTH-2:0]};
        end
    endgenerate

    dsm_modulator_1st #(
        .WIDTH   (IN_WIDTH),
        .MOD_DIV (MOD_DIV)
    ) u_mod (
        .CLK     (CLK),
        .RESET_n (RESET_n),
        .U       (u_off),
        .DOUT    (DOUT)
    );

endmodule

// File: tb/tb_sound_dsm_dac.sv
// ---------------------------------------------------------------------------
// tb_sound_dsm_dac
// Directed self-checking bench for sound_dsm_dac with IN_WIDTH=16,
// SAMPLE_DIV=4, GAIN_BITS=4, MOD_DIV=1.
// ---------------------------------------------------------------------------
module tb_sound_dsm_dac;

    localparam int IN_WIDTH   = 16;
    localparam int SAMPLE_DIV = 4;
    localparam int GAIN_BITS  = 4;
    localparam int MOD_DIV    = 1;

    logic                CLK     = 1'b0;
    logic                RESET_n = 1'b0;
    logic [IN_WIDTH-1:0] SIGNAL  = '0;
    logic                MUTE    = 1'b0;
    logic                DOUT;
    logic [GAIN_BITS:0]  GAIN;
    logic                SAMPLE_STB;

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    sound_dsm_dac #(
        .IN_WIDTH   (IN_WIDTH),
        .SAMPLE_DIV (SAMPLE_DIV),
        .GAIN_BITS  (GAIN_BITS),
        .MOD_DIV    (MOD_DIV)
    ) dut (
        .CLK        (CLK),
        .RESET_n    (RESET_n),
        .SIGNAL     (SIGNAL),
        .MUTE       (MUTE),
        .DOUT       (DOUT),
        .GAIN       (GAIN),
        .SAMPLE_STB (SAMPLE_STB)
    );

    // ---------------- checkers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input int obs, input int lo, input int hi);
        n_cmp++;
        assert (obs >= lo && obs <= hi) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Waits (bounded) for the strobe, then returns 1ns after the capture edge.
    task automatic wait_stb(input string tag, output int cycles);
        bit found;
        found  = 1'b0;
        cycles = 0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge CLK);
            cycles++;
            if (SAMPLE_STB) found = 1'b1;
        end
        n_cmp++;
        assert (found) else begin
            n_err++;
            $error("FAIL %s observed=no strobe expected=strobe within 8 cycles", tag);
        end
        @(posedge CLK);
        #1;
    endtask

    // Capture a new SIGNAL and let it reach the modulator output.
    task automatic settle(input string tag);
        int cyc;
        wait_stb(tag, cyc);
        repeat (3) @(posedge CLK);
    endtask

    task automatic count_ones(input int n, output int ones);
        ones = 0;
        repeat (n) begin
            @(negedge CLK);
            ones += int'(DOUT);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cyc;
        int ones;
        bit seen;

        // Reset state
        MUTE    = 1'b0;
        SIGNAL  = 16'h4000;
        RESET_n = 1'b0;
        repeat (3) @(negedge CLK);
        check("reset_dout", 32'(DOUT), 32'd0);
        check("reset_gain", 32'(GAIN), 32'd0);
        check("reset_stb",  32'(SAMPLE_STB), 32'd0);
        #2 RESET_n = 1'b1;

        // Ramp-up: one step per strobe, strobe period 4
        for (int k = 1; k <= 16; k++) begin
            wait_stb($sformatf("ramp_stb_%0d", k), cyc);
            check($sformatf("ramp_gain_%0d", k), 32'(GAIN), 32'(k));
            if (k >= 2) check($sformatf("stb_period_%0d", k), 32'(cyc), 32'd4);
        end
        check("stb_one_cycle", 32'(SAMPLE_STB), 32'd0);
        wait_stb("hold_stb", cyc);
        check("ramp_hold_16", 32'(GAIN), 32'd16);

        // Duty at full gain: zero input -> 50%
        SIGNAL = 16'h0000;
        settle("duty_zero");
        count_ones(1024, ones);
        check_range("duty_zero_ones", ones, 511, 513);

        // Most negative input -> constant 0
        SIGNAL = 16'h8000;
        settle("duty_min");
        count_ones(256, ones);
        check("duty_min_ones", 32'(ones), 32'd0);

        // Most positive input -> exactly one zero per 2^16 steps
        SIGNAL = 16'h7FFF;
        settle("duty_max");
        count_ones(65536, ones);
        check("duty_max_ones", 32'(ones), 32'd65535);

        // Mute ramp down, with mid-gain scaling check at GAIN=8
        SIGNAL = 16'h4000;
        MUTE   = 1'b1;
        for (int k = 15; k >= 0; k--) begin
            wait_stb($sformatf("mute_stb_%0d", k), cyc);
            check($sformatf("mute_gain_%0d", k), 32'(GAIN), 32'(k));
            if (k == 8) begin
                @(posedge CLK);
                #1;
                check("mid_scaled", 32'($unsigned(dut.scaled_r)), 32'h2000);
                check("mid_u",      32'(dut.u_off),               32'hA000);
            end
        end
        wait_stb("mute_floor_stb", cyc);
        check("mute_floor_0", 32'(GAIN), 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        check("mute_u", 32'(dut.u_off), 32'h8000);
        count_ones(1024, ones);
        check_range("mute_duty_ones", ones, 511, 513);

        // Negative sample scaling at GAIN=8
        SIGNAL = 16'h8000;
        MUTE   = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            wait_stb($sformatf("neg_stb_%0d", k), cyc);
            check($sformatf("neg_gain_%0d", k), 32'(GAIN), 32'(k));
        end
        @(posedge CLK);
        #1;
        check("neg_scaled", 32'($unsigned(dut.scaled_r)), 32'hC000);
        check("neg_u",      32'(dut.u_off),               32'h4000);

        // Mute mid-ramp, then unmute at GAIN=5
        MUTE = 1'b1;
        for (int k = 7; k >= 5; k--) begin
            wait_stb($sformatf("rev_stb_%0d", k), cyc);
            check($sformatf("rev_gain_%0d", k), 32'(GAIN), 32'(k));
        end
        MUTE = 1'b0;
        for (int k = 6; k <= 9; k++) begin
            wait_stb($sformatf("unmute_stb_%0d", k), cyc);
            check($sformatf("unmute_gain_%0d", k), 32'(GAIN), 32'(k));
        end

        // Asynchronous reset at GAIN=9 while DOUT is high
        seen = 1'b0;
        for (int i = 0; i < 32 && !seen; i++) begin
            @(negedge CLK);
            if (DOUT) seen = 1'b1;
        end
        check("pre_reset_dout_high", 32'(seen), 32'd1);
        #2 RESET_n = 1'b0;
        #1;
        check("async_reset_dout", 32'(DOUT), 32'd0);
        check("async_reset_gain", 32'(GAIN), 32'd0);
        #8;
        check("in_reset_gain", 32'(GAIN), 32'd0);
        check("in_reset_dout", 32'(DOUT), 32'd0);
        #1 RESET_n = 1'b1;

        // Ramp restarts from 0
        wait_stb("restart_stb_1", cyc);
        check("restart_gain_1", 32'(GAIN), 32'd1);
        wait_stb("restart_stb_2", cyc);
        check("restart_gain_2", 32'(GAIN), 32'd2);

        // ---------------- report ----------------
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
